game_ctrl_fsm: RTL and testbench
================================

Name: game_ctrl_fsm

Overview:
Parametrised Connect-Four game controller, successor to the fixed 7x6 two-player controller.
- Sequences each turn: input capture, move validation, board write, win/draw check.
- Clears the board itself: one column per cycle, at reset and on restart.
- Sits between the switch decoder, move validator, board memories (on/off and player) and the win-logic unit; also drives the VGA status signals.

Parameters:
COLS, 7, number of board columns (memory depth)
ROWS, 6, cells per column (on/off word width)
NPLAYERS, 2, number of players (2..4)
ADDR_W, 3, column address width; must satisfy 2**ADDR_W >= COLS
PW, 1, player id width; must satisfy 2**PW >= NPLAYERS

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
play_n  in  1  play KEY, active-low, already synchronised to clk
valid_input  in  1  decoder: switch setting is a legal column
decoder_addr  in  ADDR_W  column selected by decoder
write_to_board  in  1  validator: move legal, sampled in VALIDATE
validator_write_onoff  in  ROWS  new on/off column from validator
validator_write_player  in  ROWS*PW  new player column from validator
logic_done  in  1  win-logic result valid
logic_result  in  1  win-logic: current player has won
cur_player  out  PW  player to move
game_finished  out  1  game over (win or draw)
winner  out  PW  winning player, valid when game_finished && !draw
draw  out  1  board full with no winner
move_rejected  out  1  1-cycle pulse: validator refused the move
logic_go  out  1  1-cycle pulse: win-logic evaluates the new column
logic_reset  out  1  win-logic clear, high throughout CLEAR
onoff_write  out  1  on/off memory write enable
player_write  out  1  player memory write enable
mem_address  out  ADDR_W  memory column address
write_to_onoff  out  ROWS  on/off write data
write_to_player  out  ROWS*PW  player write data

Behaviour:
- All outputs are registered.
- Async reset:
  - State = CLEAR, clear_idx = 0, move_cnt = 0.
  - All outputs = 0; the CLEAR outputs take effect on the first clock after reset deasserts.
- Press event: a 1->0 transition of play_n, registered once.
  - Holding the key yields one event.
  - Events arriving outside WAIT_INPUT and END_GAME are discarded, not queued.
- CLEAR:
  - Each cycle: mem_address = clear_idx; onoff_write = player_write = 1; write data = 0; logic_reset = 1.
  - clear_idx increments each cycle; after column COLS-1 the next state is WAIT_INPUT. CLEAR lasts exactly COLS cycles.
  - On entry: cur_player, move_cnt, winner, draw and game_finished are cleared.
- WAIT_INPUT:
  - Write enables are 0.
  - Press event with valid_input = 1: latch decoder_addr into addr_q, go to CHECK_INPUT.
  - Press event with valid_input = 0: ignored.
- CHECK_INPUT: mem_address = addr_q for one cycle (one-cycle memory read latency), then VALIDATE.
- VALIDATE: mem_address held; sample write_to_board.
  - 1: go to UPDATE_GAME.
  - 0: pulse move_rejected, go to WAIT_INPUT; cur_player unchanged.
- UPDATE_GAME (one cycle):
  - mem_address = addr_q; onoff_write = player_write = 1.
  - Write data = the validator values; logic_go = 1; move_cnt += 1.
  - Next state CHECK_WINNER.
- CHECK_WINNER: stay until logic_done = 1, then:
  - logic_result = 1: winner = cur_player, game_finished = 1, go to END_GAME.
  - Else move_cnt == COLS*ROWS: draw = 1, game_finished = 1, go to END_GAME.
  - Else: cur_player = (cur_player == NPLAYERS-1) ? 0 : cur_player+1, go to WAIT_INPUT.
  - A win on the final cell reports a win, not a draw.
- END_GAME:
  - Hold all status outputs.
  - A press event goes to CLEAR, which restarts the game with player 0.
- Widths: move_cnt is clog2(COLS*ROWS+1) bits; it cannot exceed COLS*ROWS.
- Reset mid-operation: any state returns to CLEAR; a partial write is abandoned and the board is re-cleared.
- Illegal or unused state encodings: recover to CLEAR.

Decomposition:
- game_pkg:
  - State enum: CLEAR, WAIT_INPUT, CHECK_INPUT, VALIDATE, UPDATE_GAME, CHECK_WINNER, END_GAME.
  - Default COLS/ROWS/NPLAYERS constants.
  - clog2-based width helper.
- Sub-module play_edge_detect: registers play_n and emits the single-cycle press event. Same clk, same async active-low reset.

Test Plan:
- Reset, then release: exactly 7 cycles with onoff_write = player_write = 1, mem_address 0..6, data 0, logic_reset = 1; then WAIT_INPUT with cur_player = 0.
- Press with decoder_addr = 3, write_to_board = 1, logic_done = 1, logic_result = 0:
  - Expect one write at address 3 carrying the validator data.
  - logic_go pulses once; cur_player becomes 1.
  - Holding play_n low 20 cycles causes no second move.
- Press with write_to_board = 0: move_rejected pulses once, no write enable asserted, cur_player unchanged.
- NPLAYERS = 3: three accepted non-winning moves -> cur_player sequence 0, 1, 2, 0.
- logic_result = 1 on the move by player 1 -> winner = 1, game_finished = 1, draw = 0.
  - A press while finished triggers a 7-cycle CLEAR, then cur_player = 0 and game_finished = 0.
- COLS = 2, ROWS = 2, 4 accepted moves with logic_result = 0 -> draw = 1, game_finished = 1.
  - Assert reset mid-UPDATE_GAME -> outputs 0 immediately, then CLEAR.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the Connect-Four game controller.
package game_pkg;

    localparam int DEF_COLS     = 7;
    localparam int DEF_ROWS     = 6;
    localparam int DEF_NPLAYERS = 2;

    typedef enum logic [2:0] {
        CLEAR        = 3'd0,
        WAIT_INPUT   = 3'd1,
        CHECK_INPUT  = 3'd2,
        VALIDATE     = 3'd3,
        UPDATE_GAME  = 3'd4,
        CHECK_WINNER = 3'd5,
        END_GAME     = 3'd6
    } state_t;

    // Bits needed to hold a counter ranging over 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/play_edge_detect.sv
// Turns the synchronised active-low play key into a one-cycle press event.
module play_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic play_n,
    output logic press
);

    logic play_reg;

    // Idle-high reset value so a key already held at reset is not a press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            play_reg <= 1'b1;
            press    <= 1'b0;
        end else begin
            play_reg <= play_n;
            press    <= play_reg & ~play_n;
        end
    end

endmodule

// File: rtl/game_ctrl_fsm.sv
// Connect-Four turn sequencer: board clear, move capture/validate/write, win/draw tracking.
module game_ctrl_fsm
    import game_pkg::*;
#(
    parameter int COLS     = DEF_COLS,
    parameter int ROWS     = DEF_ROWS,
    parameter int NPLAYERS = DEF_NPLAYERS,
    parameter int ADDR_W   = 3,
    parameter int PW       = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 play_n,
    input  logic                 valid_input,
    input  logic [ADDR_W-1:0]    decoder_addr,
    input  logic                 write_to_board,
    input  logic [ROWS-1:0]      validator_write_onoff,
    input  logic [ROWS*PW-1:0]   validator_write_player,
    input  logic                 logic_done,
    input  logic                 logic_result,
    output logic [PW-1:0]        cur_player,
    output logic                 game_finished,
    output logic [PW-1:0]        winner,
    output logic                 draw,
    output logic                 move_rejected,
    output logic                 logic_go,
    output logic                 logic_reset,
    output logic                 onoff_write,
    output logic                 player_write,
    output logic [ADDR_W-1:0]    mem_address,
    output logic [ROWS-1:0]      write_to_onoff,
    output logic [ROWS*PW-1:0]   write_to_player
);

    localparam int CELLS = COLS * ROWS;
    localparam int MCW   = cnt_width(CELLS);

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   clear_idx_reg, clear_idx_next;
    logic [ADDR_W-1:0]   addr_q_reg, addr_q_next;
    logic [MCW-1:0]      move_cnt_reg, move_cnt_next;
    logic                press;

    logic [PW-1:0]       cur_player_next, winner_next;
    logic                game_finished_next, draw_next;
    logic                move_rejected_next, logic_go_next, logic_reset_next;
    logic                onoff_write_next, player_write_next;
    logic [ADDR_W-1:0]   mem_address_next;
    logic [ROWS-1:0]     write_to_onoff_next;
    logic [ROWS*PW-1:0]  write_to_player_next;

    play_edge_detect u_edge (
        .clk    (clk),
        .reset  (reset),
        .play_n (play_n),
        .press  (press)
    );

    always_comb begin
        state_next           = state_reg;
        clear_idx_next       = clear_idx_reg;
        addr_q_next          = addr_q_reg;
        move_cnt_next        = move_cnt_reg;
        cur_player_next      = cur_player;
        winner_next          = winner;
        game_finished_next   = game_finished;
        draw_next            = draw;
        move_rejected_next   = 1'b0;
        logic_go_next        = 1'b0;
        logic_reset_next     = 1'b0;
        onoff_write_next     = 1'b0;
        player_write_next    = 1'b0;
        mem_address_next     = mem_address;
        write_to_onoff_next  = '0;
        write_to_player_next = '0;

        case (state_reg)
            CLEAR: begin
                mem_address_next   = clear_idx_reg;
                onoff_write_next   = 1'b1;
                player_write_next  = 1'b1;
                logic_reset_next   = 1'b1;
                cur_player_next    = '0;
                move_cnt_next      = '0;
                winner_next        = '0;
                draw_next          = 1'b0;
                game_finished_next = 1'b0;
                if (clear_idx_reg == ADDR_W'(COLS - 1)) begin
                    clear_idx_next = '0;
                    state_next     = WAIT_INPUT;
                end else begin
                    clear_idx_next = clear_idx_reg + 1'b1;
                end
            end
            WAIT_INPUT: begin
                if (press && valid_input) begin
                    addr_q_next = decoder_addr;
                    state_next  = CHECK_INPUT;
                end
            end
            CHECK_INPUT: begin
                // The memory needs one cycle to present the addressed column.
                mem_address_next = addr_q_reg;
                state_next       = VALIDATE;
            end
            VALIDATE: begin
                mem_address_next = addr_q_reg;
                if (write_to_board) begin
                    state_next = UPDATE_GAME;
                end else begin
                    move_rejected_next = 1'b1;
                    state_next         = WAIT_INPUT;
                end
            end
            UPDATE_GAME: begin
                mem_address_next     = addr_q_reg;
                onoff_write_next     = 1'b1;
                player_write_next    = 1'b1;
                write_to_onoff_next  = validator_write_onoff;
                write_to_player_next = validator_write_player;
                logic_go_next        = 1'b1;
                move_cnt_next        = move_cnt_reg + 1'b1;
                state_next           = CHECK_WINNER;
            end
            CHECK_WINNER: begin
                if (logic_done) begin
                    // A win on the last free cell takes priority over a draw.
                    if (logic_result) begin
                        winner_next        = cur_player;
                        game_finished_next = 1'b1;
                        state_next         = END_GAME;
                    end else if (move_cnt_reg == MCW'(CELLS)) begin
                        draw_next          = 1'b1;
                        game_finished_next = 1'b1;
                        state_next         = END_GAME;
                    end else begin
                        cur_player_next = (cur_player == PW'(NPLAYERS - 1)) ? '0
                                                                            : cur_player + 1'b1;
                        state_next      = WAIT_INPUT;
                    end
                end
            end
            END_GAME: begin
                if (press) begin
                    state_next = CLEAR;
                end
            end
            default: begin
                clear_idx_next = '0;
                state_next     = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= CLEAR;
            clear_idx_reg   <= '0;
            addr_q_reg      <= '0;
            move_cnt_reg    <= '0;
            cur_player      <= '0;
            winner          <= '0;
            game_finished   <= 1'b0;
            draw            <= 1'b0;
            move_rejected   <= 1'b0;
            logic_go        <= 1'b0;
            logic_reset     <= 1'b0;
            onoff_write     <= 1'b0;
            player_write    <= 1'b0;
            mem_address     <= '0;
            write_to_onoff  <= '0;
            write_to_player <= '0;
        end else begin
            state_reg       <= state_next;
            clear_idx_reg   <= clear_idx_next;
            addr_q_reg      <= addr_q_next;
            move_cnt_reg    <= move_cnt_next;
            cur_player      <= cur_player_next;
            winner          <= winner_next;
            game_finished   <= game_finished_next;
            draw            <= draw_next;
            move_rejected   <= move_rejected_next;
            logic_go        <= logic_go_next;
            logic_reset     <= logic_reset_next;
            onoff_write     <= onoff_write_next;
            player_write    <= player_write_next;
            mem_address     <= mem_address_next;
            write_to_onoff  <= write_to_onoff_next;
            write_to_player <= write_to_player_next;
        end
    end

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Directed bench: default 7x6 two-player controller (A) and a 2x2 three-player controller (B).
module tb_game_ctrl_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_a, reset_b, play_a, play_b;
    logic       valid_input, wtb, logic_done, logic_result;
    logic [2:0] dec_addr;
    logic [5:0] v_onoff, v_player;

    logic       a_cur, a_win, a_fin, a_draw, a_rej, a_go, a_lrst, a_owe, a_pwe;
    logic [2:0] a_addr;
    logic [5:0] a_won, a_wp;

    logic [1:0] b_cur, b_win, b_won;
    logic       b_fin, b_draw, b_rej, b_go, b_lrst, b_owe, b_pwe;
    logic [0:0] b_addr;
    logic [3:0] b_wp;

    game_ctrl_fsm u_a (
        .clk(clk), .reset(reset_a), .play_n(play_a), .valid_input(valid_input),
        .decoder_addr(dec_addr), .write_to_board(wtb),
        .validator_write_onoff(v_onoff), .validator_write_player(v_player),
        .logic_done(logic_done), .logic_result(logic_result),
        .cur_player(a_cur), .game_finished(a_fin), .winner(a_win), .draw(a_draw),
        .move_rejected(a_rej), .logic_go(a_go), .logic_reset(a_lrst),
        .onoff_write(a_owe), .player_write(a_pwe), .mem_address(a_addr),
        .write_to_onoff(a_won), .write_to_player(a_wp)
    );

    game_ctrl_fsm #(.COLS(2), .ROWS(2), .NPLAYERS(3), .ADDR_W(1), .PW(2)) u_b (
        .clk(clk), .reset(reset_b), .play_n(play_b), .valid_input(valid_input),
        .decoder_addr(dec_addr[0:0]), .write_to_board(wtb),
        .validator_write_onoff(v_onoff[1:0]), .validator_write_player(v_player[3:0]),
        .logic_done(logic_done), .logic_result(logic_result),
        .cur_player(b_cur), .game_finished(b_fin), .winner(b_win), .draw(b_draw),
        .move_rejected(b_rej), .logic_go(b_go), .logic_reset(b_lrst),
        .onoff_write(b_owe), .player_write(b_pwe), .mem_address(b_addr),
        .write_to_onoff(b_won), .write_to_player(b_wp)
    );

    // Observed view of whichever instance is under test.
    logic       sel;
    logic [1:0] o_cur, o_win;
    logic [2:0] o_addr;
    logic [5:0] o_won, o_wp;
    logic       o_fin, o_draw, o_rej, o_go, o_lrst, o_owe, o_pwe;

    always_comb begin
        if (!sel) begin
            o_cur = {1'b0, a_cur}; o_win = {1'b0, a_win}; o_addr = a_addr;
            o_won = a_won; o_wp = a_wp; o_fin = a_fin; o_draw = a_draw;
            o_rej = a_rej; o_go = a_go; o_lrst = a_lrst; o_owe = a_owe; o_pwe = a_pwe;
        end else begin
            o_cur = b_cur; o_win = b_win; o_addr = {2'b00, b_addr};
            o_won = {4'b0, b_won}; o_wp = {2'b00, b_wp}; o_fin = b_fin; o_draw = b_draw;
            o_rej = b_rej; o_go = b_go; o_lrst = b_lrst; o_owe = b_owe; o_pwe = b_pwe;
        end
    end

    typedef struct {
        bit         inst;
        bit         valid;
        logic [2:0] addr;
        bit         wr;
        bit         res;
        logic [5:0] von;
        logic [5:0] vpl;
        int         exp_wr;
        int         exp_rej;
        logic [1:0] exp_cur;
        bit         exp_fin;
        logic [1:0] exp_win;
        bit         exp_draw;
    } vec_t;

    vec_t vecs[15];
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_play(input logic v);
        if (!sel) play_a = v; else play_b = v;
    endtask

    // Counts clear writes over a bounded window; addresses must run 0..ncols-1 with zero data.
    task automatic watch_clear(input int ncols, input string tag);
        int cnt = 0;
        bit bad = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (o_owe) begin
                if (!(o_pwe && o_lrst && o_won == 6'd0 && o_wp == 6'd0 && o_addr == 3'(cnt)))
                    bad = 1'b1;
                cnt++;
            end
        end
        $display("%s: %0d clear writes", tag, cnt);
        chk({tag, " clear count"}, cnt, ncols);
        chk({tag, " clear content"}, {31'd0, bad}, 0);
        chk({tag, " cur after clear"}, {30'd0, o_cur}, 0);
        chk({tag, " finished after clear"}, {31'd0, o_fin}, 0);
        chk({tag, " winner after clear"}, {30'd0, o_win}, 0);
    endtask

    task automatic do_move(input int i);
        vec_t v = vecs[i];
        int nw = 0, ngo = 0, nrej = 0;
        bit we_split = 1'b0;
        logic [2:0] w_addr = '0;
        logic [5:0] w_on = '0, w_pl = '0;
        sel = v.inst;
        valid_input = v.valid; dec_addr = v.addr; wtb = v.wr; logic_result = v.res;
        v_onoff = v.von; v_player = v.vpl;
        @(negedge clk);
        set_play(1'b0);
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (k == 20) set_play(1'b1);
            if (o_owe != o_pwe) we_split = 1'b1;
            if (o_owe) begin nw++; w_addr = o_addr; w_on = o_won; w_pl = o_wp; end
            if (o_go) ngo++;
            if (o_rej) nrej++;
        end
        repeat (3) @(negedge clk);
        $display("move %0d inst=%0d addr=%0d wr=%0d res=%0d -> writes=%0d go=%0d rej=%0d cur=%0d fin=%0d win=%0d draw=%0d",
                 i, v.inst, v.addr, v.wr, v.res, nw, ngo, nrej, o_cur, o_fin, o_win, o_draw);
        chk($sformatf("v%0d writes", i), nw, v.exp_wr);
        chk($sformatf("v%0d logic_go", i), ngo, v.exp_wr);
        chk($sformatf("v%0d rejected", i), nrej, v.exp_rej);
        chk($sformatf("v%0d we pair", i), {31'd0, we_split}, 0);
        if (v.exp_wr == 1) begin
            chk($sformatf("v%0d addr", i), {29'd0, w_addr}, {29'd0, v.addr});
            chk($sformatf("v%0d onoff data", i), {26'd0, w_on}, {26'd0, v.von});
            chk($sformatf("v%0d player data", i), {26'd0, w_pl}, {26'd0, v.vpl});
        end
        chk($sformatf("v%0d cur", i), {30'd0, o_cur}, {30'd0, v.exp_cur});
        chk($sformatf("v%0d finished", i), {31'd0, o_fin}, {31'd0, v.exp_fin});
        chk($sformatf("v%0d winner", i), {30'd0, o_win}, {30'd0, v.exp_win});
        chk($sformatf("v%0d draw", i), {31'd0, o_draw}, {31'd0, v.exp_draw});
    endtask

    task automatic reset_b_and_clear(input string tag);
        @(negedge clk); reset_b = 1'b0;
        repeat (2) @(negedge clk);
        reset_b = 1'b1;
        watch_clear(2, tag);
    endtask

    initial begin
        //           inst val addr wr res  von     vpl   wr rej cur fin win draw
        vecs[0]  = '{0, 1, 3'd3, 1, 0, 6'h03, 6'h2a, 1, 0, 2'd1, 0, 2'd0, 0};
        vecs[1]  = '{0, 1, 3'd5, 0, 0, 6'h3f, 6'h3f, 0, 1, 2'd1, 0, 2'd0, 0};
        vecs[2]  = '{0, 0, 3'd2, 1, 0, 6'h01, 6'h01, 0, 0, 2'd1, 0, 2'd0, 0};
        vecs[3]  = '{0, 1, 3'd2, 1, 0, 6'h01, 6'h01, 1, 0, 2'd0, 0, 2'd0, 0};
        vecs[4]  = '{0, 1, 3'd0, 1, 0, 6'h07, 6'h00, 1, 0, 2'd1, 0, 2'd0, 0};
        vecs[5]  = '{0, 1, 3'd6, 1, 1, 6'h21, 6'h14, 1, 0, 2'd1, 1, 2'd1, 0};
        vecs[6]  = '{1, 1, 3'd0, 1, 0, 6'h01, 6'h00, 1, 0, 2'd1, 0, 2'd0, 0};
        vecs[7]  = '{1, 1, 3'd1, 1, 0, 6'h01, 6'h01, 1, 0, 2'd2, 0, 2'd0, 0};
        vecs[8]  = '{1, 1, 3'd0, 1, 0, 6'h03, 6'h09, 1, 0, 2'd0, 0, 2'd0, 0};
        vecs[9]  = '{1, 1, 3'd1, 1, 0, 6'h03, 6'h06, 1, 0, 2'd0, 1, 2'd0, 1};
        vecs[10] = '{1, 1, 3'd0, 1, 0, 6'h01, 6'h00, 1, 0, 2'd1, 0, 2'd0, 0};
        vecs[11] = '{1, 1, 3'd1, 1, 0, 6'h01, 6'h01, 1, 0, 2'd2, 0, 2'd0, 0};
        vecs[12] = '{1, 1, 3'd0, 1, 0, 6'h03, 6'h09, 1, 0, 2'd0, 0, 2'd0, 0};
        vecs[13] = '{1, 1, 3'd1, 1, 1, 6'h03, 6'h02, 1, 0, 2'd0, 1, 2'd0, 0};
        vecs[14] = '{1, 1, 3'd1, 1, 0, 6'h02, 6'h04, 1, 0, 2'd1, 0, 2'd0, 0};

        sel = 1'b0;
        reset_a = 1'b0; reset_b = 1'b0; play_a = 1'b1; play_b = 1'b1;
        valid_input = 1'b1; wtb = 1'b0; logic_done = 1'b1; logic_result = 1'b0;
        dec_addr = '0; v_onoff = '0; v_player = '0;

        #1;
        chk("reset onoff_write", {31'd0, o_owe}, 0);
        chk("reset logic_reset", {31'd0, o_lrst}, 0);
        chk("reset mem_address", {29'd0, o_addr}, 0);
        chk("reset cur_player", {30'd0, o_cur}, 0);
        repeat (3) @(negedge clk);
        chk("held reset onoff_write", {31'd0, o_owe}, 0);
        reset_a = 1'b1; reset_b = 1'b1;
        watch_clear(7, "A power-up");

        for (int i = 0; i <= 5; i++) do_move(i);

        // Press while finished restarts with a full clear.
        @(negedge clk); play_a = 1'b0;
        watch_clear(7, "A restart");
        play_a = 1'b1;
        chk("A restart draw", {31'd0, o_draw}, 0);

        sel = 1'b1;
        reset_b_and_clear("B reset");
        for (int i = 6; i <= 9; i++) do_move(i);

        @(negedge clk); play_b = 1'b0;
        watch_clear(2, "B restart");
        play_b = 1'b1;
        for (int i = 10; i <= 13; i++) do_move(i);

        reset_b_and_clear("B reset2");
        do_move(14);

        // Reset while the board write is being issued.
        valid_input = 1'b1; dec_addr = 3'd0; wtb = 1'b1; logic_result = 1'b0;
        v_onoff = 6'h03; v_player = 6'h0f;
        @(negedge clk); play_b = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset_b = 1'b0;
        #1;
        $display("mid-update reset: owe=%0d go=%0d cur=%0d", o_owe, o_go, o_cur);
        chk("midreset cur_player", {30'd0, o_cur}, 0);
        chk("midreset onoff_write", {31'd0, o_owe}, 0);
        chk("midreset logic_go", {31'd0, o_go}, 0);
        @(negedge clk); play_b = 1'b1;
        @(negedge clk); reset_b = 1'b1;
        watch_clear(2, "B after midreset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
